router_fsm_ctrl: RTL and testbench
==================================

// Module: router_fsm_ctrl
// PURPOSE
//  Moore controller that sequences the router input register and the write-side of the 1x3 FIFO bank.
//  Decodes the header address, then steps the register through header load, payload load, parity load and parity check.
//  Stalls on FIFO-full and waits for the destination FIFO to drain. Sits between the input port and router_register/synchronizer.
// PARAMETERS
//  ADDR_W          2    width of header address field (data_in[1:0]); addresses 0..2 valid, 3 = drop
//  TIMEOUT_CYCLES  30   WAIT_TILL_EMPTY watchdog limit (used only with ROUTER_WAIT_TIMEOUT_EN)
// PORTS
//  clk            in   1  system clock; one clock domain
//  rst            in   1  synchronous, active-high reset
//  pkt_valid      in   1  packet in progress on input port
//  data_in        in   2  header address bits, sampled in DECODE_ADDRESS
//  fifo_full      in   1  addressed FIFO full (from synchronizer)
//  fifo_empty     in   3  per-FIFO empty flags, index = address
//  soft_reset     in   3  per-FIFO soft reset (read-side timeout), index = address
//  parity_done    in   1  register has captured source parity
//  low_pkt_valid  in   1  register saw pkt_valid fall while stalled
//  detect_add     out  1  state==DECODE_ADDRESS
//  lfd_state      out  1  state==LOAD_FIRST_DATA
//  ld_state       out  1  state==LOAD_DATA
//  laf_state      out  1  state==LOAD_AFTER_FULL
//  full_state     out  1  state==FIFO_FULL_STATE
//  rst_int_reg    out  1  state==CHECK_PARITY_ERROR
//  write_enb_reg  out  1  FIFO write enable: LFD|LD|LOAD_PARITY|LAF
//  busy           out  1  back-pressure: high in all states except DECODE_ADDRESS, LOAD_DATA
//  wait_timeout   out  1  one-cycle pulse on watchdog expiry (0 when macro absent)
// BEHAVIOUR
//  - Reset: state=DECODE_ADDRESS, addr_q=0, timer=0 -> detect_add=1, all other outputs 0.
//  - All outputs are pure decodes of registered state; change one cycle after the deciding input edge.
//  - addr_q <= data_in when state==DECODE_ADDRESS && pkt_valid; held elsewhere.
//  - DECODE: pkt_valid & data_in<3 & fifo_empty[data_in] -> LFD; pkt_valid & data_in<3 & !empty -> WAIT_TILL_EMPTY;
//    data_in==3 or !pkt_valid -> stay (addr-3 packet silently dropped).
//  - LFD -> LOAD_DATA unconditionally (header written, exactly 1 cycle).
//  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
//  - LOAD_PARITY -> CHECK_PARITY_ERROR.  CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE else DECODE.
//  - FIFO_FULL_STATE: stay while fifo_full; else -> LOAD_AFTER_FULL.
//  - LAF: parity_done -> DECODE; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
//  - WAIT_TILL_EMPTY: fifo_empty[addr_q] -> LFD; else stay.
//  - Priority: rst > soft_reset[addr_q] (any state except DECODE -> DECODE) > normal transitions.
//  - soft_reset on a non-addressed FIFO is ignored. Simultaneous fifo_full & !pkt_valid in LOAD_DATA -> FULL wins.
//  - Reset asserted mid-packet abandons the packet; no partial-state recovery.
// CONFIGURATION
//  ROUTER_WAIT_TIMEOUT_EN defined: timer counts cycles in WAIT_TILL_EMPTY (clears on any other state);
//   at count==TIMEOUT_CYCLES-1 without empty -> DECODE next cycle, wait_timeout=1 for that one cycle.
//  Undefined: no timer, WAIT_TILL_EMPTY waits indefinitely, wait_timeout tied 0.
// STRUCTURE
//  router_pkg: state localparams (3-bit, DECODE_ADDRESS=0 .. WAIT_TILL_EMPTY=7), ADDR_DROP=2'b11.
//  Sub-module router_wait_timer (counter + expiry pulse), instantiated only under ROUTER_WAIT_TIMEOUT_EN.
//  Top: state reg, next-state comb block, addr_q reg, output decode.
// TESTING
//  T1 rst=1 2 cycles -> detect_add=1, busy=0, write_enb_reg=0, others 0.
//  T2 header 0x16 (addr 2, len 5), fifo_empty=3'b111, no full -> DECODE,LFD,LD x5,LP,CPE,DECODE; write_enb 7 cycles.
//  T3 fifo_full=1 on 3rd payload -> FULL held 4 cycles, full_state=1, busy=1; release -> LAF then LD.
//  T4 header addr 1, fifo_empty=3'b101 -> WAIT_TILL_EMPTY; fifo_empty[1]=1 at cycle 6 -> LFD next cycle.
//  T5 in LOAD_DATA addr 2: soft_reset=3'b001 -> no effect; soft_reset=3'b100 -> DECODE next cycle.
//  T6 header data_in=2'b11, pkt_valid=1 -> stays DECODE; with macro, WAIT 30 cycles -> wait_timeout pulse, DECODE.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types for the router write-side controller: FSM state encoding,
// the reserved drop address, and an address-indexed flag selector.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_e;

  localparam logic [1:0] ADDR_DROP = 2'b11;

  // Pick the per-FIFO flag for an address; the drop address maps to 0
  // so no out-of-range index is ever formed.
  function automatic logic addr_sel(input logic [2:0] vec, input logic [1:0] addr);
    case (addr)
      2'd0:    addr_sel = vec[0];
      2'd1:    addr_sel = vec[1];
      2'd2:    addr_sel = vec[2];
      default: addr_sel = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Watchdog for WAIT_TILL_EMPTY: counts cycles spent waiting and flags expiry.
// Only instantiated when ROUTER_WAIT_TIMEOUT_EN is defined.
module router_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic leave,
  output logic expire,
  output logic wait_timeout
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  // Expiry only when the wait is not already ending for another reason,
  // so the pulse always means the watchdog caused the exit.
  always_comb begin
    expire = run && !leave && (count == CW'(TIMEOUT_CYCLES - 1));
  end

  // Cycle counter plus registered one-cycle expiry pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      wait_timeout <= 1'b0;
    end else begin
      wait_timeout <= expire;
      if (run && !leave && !expire)
        count <= count + CW'(1);
      else
        count <= '0;
    end
  end

endmodule

// File: rtl/router_fsm_ctrl.sv
// Moore controller sequencing the router input register and FIFO write side.
// Optional WAIT_TILL_EMPTY watchdog enabled by defining ROUTER_WAIT_TIMEOUT_EN.
module router_fsm_ctrl
  import router_pkg::*;
#(
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [2:0]        fifo_empty,
  input  logic [2:0]        soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
  output logic              wait_timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("router_fsm_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  router_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              empty_hit;
  logic              soft_hit;
  logic              timeout_expire;

  // Flags of the FIFO latched at header decode.
  always_comb begin
    empty_hit = addr_sel(fifo_empty, addr_q);
    soft_hit  = addr_sel(soft_reset, addr_q);
  end

`ifdef ROUTER_WAIT_TIMEOUT_EN
  router_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (state_q == WAIT_TILL_EMPTY),
    .leave       (empty_hit || soft_hit),
    .expire      (timeout_expire),
    .wait_timeout(wait_timeout)
  );
`else
  // No watchdog: waiting for the FIFO to drain is unbounded.
  always_comb begin
    timeout_expire = 1'b0;
    wait_timeout   = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= DECODE_ADDRESS;
    else     state_q <= state_d;
  end

  // Header address capture while decoding.
  always_ff @(posedge clk) begin
    if (rst)
      addr_q <= '0;
    else if (state_q == DECODE_ADDRESS && pkt_valid)
      addr_q <= data_in;
  end

  // Next-state logic; soft reset of the addressed FIFO overrides all flow.
  always_comb begin
    state_d = state_q;
    if (state_q != DECODE_ADDRESS && soft_hit) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != ADDR_DROP)
            state_d = addr_sel(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:
          state_d = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        LOAD_PARITY:
          state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        FIFO_FULL_STATE:
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        WAIT_TILL_EMPTY:
          if (empty_hit)           state_d = LOAD_FIRST_DATA;
          else if (timeout_expire) state_d = DECODE_ADDRESS;
        default:
          state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode of the registered state.
  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = lfd_state || ld_state || laf_state || (state_q == LOAD_PARITY);
    busy          = !(detect_add || ld_state);
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: directed table, hand sequences
// for multi-cycle corners, then randomized traffic against a reference model.
module tb_router_fsm_ctrl;

  localparam int unsigned TIMEOUT = 30;
`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Expected output vectors {detect_add,lfd,ld,laf,full,rst_int,wen,busy}
  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0011;
  localparam logic [7:0] O_LD   = 8'b0010_0010;
  localparam logic [7:0] O_LP   = 8'b0000_0011;
  localparam logic [7:0] O_CPE  = 8'b0000_0101;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LAF  = 8'b0001_0011;
  localparam logic [7:0] O_WAIT = 8'b0000_0001;

  logic       clk = 1'b0;
  logic       rst = 1'b0, pkt_valid = 1'b0, fifo_full = 1'b0;
  logic       parity_done = 1'b0, low_pkt_valid = 1'b0;
  logic [1:0] data_in = '0;
  logic [2:0] fifo_empty = '0, soft_reset = '0;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy, wait_timeout;

  router_fsm_ctrl #(.ADDR_W(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .wait_timeout(wait_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, pv;
    logic [1:0] d;
    logic       ff;
    logic [2:0] fe, sr;
    logic       pd, lpv;
    logic [7:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: packet phase by name, the latched destination, and
  // how long the current wait for a drain has lasted.
  typedef enum {PH_IDLE, PH_HDR, PH_BODY, PH_PAR, PH_CHK, PH_STALL, PH_RESUME, PH_WAIT} phase_t;
  phase_t m_ph = PH_IDLE;
  int     m_addr = 0;
  int     m_waited = 0;
  bit     m_wt = 1'b0;

  function automatic bit flag_of(input logic [2:0] v, input int a);
    return (a < 3) ? v[a] : 1'b0;
  endfunction

  function automatic logic [7:0] out_of(input phase_t p);
    case (p)
      PH_IDLE:   return O_DEC;
      PH_HDR:    return O_LFD;
      PH_BODY:   return O_LD;
      PH_PAR:    return O_LP;
      PH_CHK:    return O_CPE;
      PH_STALL:  return O_FULL;
      PH_RESUME: return O_LAF;
      default:   return O_WAIT;
    endcase
  endfunction

  task automatic model_advance();
    phase_t nx = m_ph;
    bit     wt = 1'b0;
    if (rst) begin
      nx = PH_IDLE;
      m_addr = 0;
    end else begin
      if (m_ph != PH_IDLE && flag_of(soft_reset, m_addr)) nx = PH_IDLE;
      else begin
        case (m_ph)
          PH_IDLE:   if (pkt_valid && data_in != 2'b11)
                       nx = flag_of(fifo_empty, int'(data_in)) ? PH_HDR : PH_WAIT;
          PH_HDR:    nx = PH_BODY;
          PH_BODY:   nx = fifo_full ? PH_STALL : (!pkt_valid ? PH_PAR : PH_BODY);
          PH_PAR:    nx = PH_CHK;
          PH_CHK:    nx = fifo_full ? PH_STALL : PH_IDLE;
          PH_STALL:  nx = fifo_full ? PH_STALL : PH_RESUME;
          PH_RESUME: nx = parity_done ? PH_IDLE : (low_pkt_valid ? PH_PAR : PH_BODY);
          PH_WAIT: begin
            if (flag_of(fifo_empty, m_addr)) nx = PH_HDR;
            else if (TMO_EN && m_waited + 1 >= int'(TIMEOUT)) begin
              nx = PH_IDLE;
              wt = 1'b1;
            end
          end
          default:   nx = PH_IDLE;
        endcase
      end
      if (m_ph == PH_IDLE && pkt_valid) m_addr = int'(data_in);
    end
    m_waited = (nx == PH_WAIT && m_ph == PH_WAIT) ? m_waited + 1 : 0;
    m_ph = nx;
    m_wt = wt;
  endtask

  task automatic step(input vec_t v);
    rst = v.rst; pkt_valid = v.pv; data_in = v.d; fifo_full = v.ff;
    fifo_empty = v.fe; soft_reset = v.sr; parity_done = v.pd; low_pkt_valid = v.lpv;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] e, input logic ew);
    logic [8:0] act;
    act = {detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy, wait_timeout};
    n_vec++;
    if (act !== {e, ew}) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, {e, ew});
    end
  endtask

  function automatic vec_t mk(input logic r, input logic pv, input logic [1:0] d,
                              input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                              input logic pd, input logic lpv, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.pv = pv; v.d = d; v.ff = ff; v.fe = fe; v.sr = sr;
    v.pd = pd; v.lpv = lpv; v.exp = e;
    return v;
  endfunction

  task automatic go(input string name, input logic r, input logic pv, input logic [1:0] d,
                    input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                    input logic pd, input logic lpv, input logic [7:0] e);
    step(mk(r, pv, d, ff, fe, sr, pd, lpv, e));
    check(name, e, 1'b0);
  endtask

  vec_t tbl[11];

  initial begin
    // Reset, then a clean 5-byte packet to address 2.
    tbl[0]  = mk(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DEC);
    tbl[1]  = mk(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DEC);
    tbl[2]  = mk(0, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    tbl[3]  = mk(0, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LD);
    tbl[4]  = mk(0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    tbl[5]  = mk(0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_LD);
    tbl[6]  = mk(0, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LD);
    tbl[7]  = mk(0, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LD);
    tbl[8]  = mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LP);
    tbl[9]  = mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_CPE);
    tbl[10] = mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DEC);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i]);
      check($sformatf("tbl[%0d]", i), tbl[i].exp, 1'b0);
    end

    // FIFO full on third payload: stall 4 cycles, resume, then full paths out of LAF/CPE.
    go("t3_rst",  1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DEC);
    go("t3_hdr",  0, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    go("t3_ld1",  0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    go("t3_ld2",  0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    for (int i = 0; i < 4; i++)
      go($sformatf("t3_full%0d", i), 0, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FULL);
    go("t3_laf",  0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF);
    go("t3_ld3",  0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    go("t3_full", 0, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FULL);
    go("t3_laf2", 0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF);
    go("t3_lp",   0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 1, O_LP);
    go("t3_cpe",  0, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_CPE);
    go("t3_cfull",0, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FULL);
    go("t3_laf3", 0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LAF);
    go("t3_pdone",0, 0, 2'd0, 0, 3'b111, 3'b000, 1, 0, O_DEC);

    // Destination busy: wait, then drain releases into header load.
    go("t4_hdr",  0, 1, 2'd1, 0, 3'b101, 3'b000, 0, 0, O_WAIT);
    for (int i = 0; i < 5; i++)
      go($sformatf("t4_wait%0d", i), 0, 1, 2'd0, 0, 3'b101, 3'b000, 0, 0, O_WAIT);
    go("t4_drain",0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LFD);

    // Soft reset: only the addressed FIFO matters.
    go("t5_rst",  1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DEC);
    go("t5_hdr",  0, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    go("t5_ld",   0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    go("t5_sr_other", 0, 1, 2'd0, 0, 3'b111, 3'b001, 0, 0, O_LD);
    go("t5_sr_own",   0, 1, 2'd0, 0, 3'b111, 3'b100, 0, 0, O_DEC);
    // Full and end-of-packet together: full wins.
    go("t5_hdr2", 0, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LFD);
    go("t5_ld2",  0, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_LD);
    go("t5_fullwin", 0, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, O_FULL);
    go("t5_rst2", 1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, O_DEC);

    // Address 3 is dropped.
    for (int i = 0; i < 3; i++)
      go($sformatf("t6_drop%0d", i), 0, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DEC);

    if (TMO_EN) begin
      go("t6_enter", 0, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WAIT);
      for (int i = 1; i < int'(TIMEOUT); i++)
        go($sformatf("t6_wait%0d", i), 0, 0, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_WAIT);
      step(mk(0, 0, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_DEC));
      check("t6_expire", O_DEC, 1'b1);
      go("t6_after", 0, 0, 2'd0, 0, 3'b011, 3'b000, 0, 0, O_DEC);
    end

    // Randomized traffic against the reference model.
    step(mk(1, 0, 2'd0, 0, 3'b000, 3'b000, 0, 0, O_DEC));
    check("rnd_reset", out_of(m_ph), m_wt);
    for (int i = 0; i < 1500; i++) begin
      vec_t v;
      v.rst = ($urandom_range(0, 59) == 0);
      v.pv  = ($urandom_range(0, 3) != 0);
      v.d   = 2'($urandom_range(0, 3));
      v.ff  = ($urandom_range(0, 3) == 0);
      v.fe  = 3'($urandom_range(0, 7));
      v.sr  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      v.pd  = ($urandom_range(0, 3) == 0);
      v.lpv = ($urandom_range(0, 2) == 0);
      v.exp = '0;
      step(v);
      check($sformatf("rnd[%0d]", i), out_of(m_ph), m_wt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
